tagger_edge_encoder: RTL
========================

# tagger_edge_encoder

Multi-channel edge encoder for the TimeTagger input path: takes per-channel oversampled words of `1<<BITS` samples per `clk`, finds the earliest qualifying edge per channel, including edges that straddle the clock boundary, and emits a registered tag of coarse cycle count plus sub-cycle index. It extends the single-channel falling-edge BCD converter with channel count, per-channel edge-polarity selection, cross-word edge history, a shared coarse counter and a multi-edge flag. It sits between the deserialising input samplers and the tag FIFO.

## Interface
- `BITS`, 2: sub-cycle index width; `N = 1<<BITS` samples per channel per cycle.
- `CHANNELS`, 4: number of input channels.
- `COUNTER_BITS`, 32: coarse timestamp width.
- `clk`  in  1  sole clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `samples`  in  `CHANNELS*N`  channel c occupies `[c*N +: N]`; bit 0 is earliest in time, bit N-1 latest.
- `edge_sel`  in  `2*CHANNELS`  per channel `[2c +: 2]`: 00 disabled, 01 rising, 10 falling, 11 both; sampled with `samples`.
- `tag_valid`  out  `CHANNELS`  qualifying edge found for channel c.
- `tag_time`  out  `CHANNELS*(COUNTER_BITS+BITS)`  per channel `{coarse, subtime}`.
- `tag_rising`  out  `CHANNELS`  1 = reported edge is rising, 0 = falling.
- `tag_multi`  out  `CHANNELS`  more than one qualifying edge in the same word; only the earliest is reported.
- `coarse_wrap`  out  1  one-cycle pulse when coarse counter wraps all-ones to 0.

## Operation
- Edge definition per channel: extended word `e = {samples_c, last_c}`, where `last_c` is the registered bit N-1 of that channel's previous word. Edge at index i (0..N-1) iff `e[i+1] != e[i]`; rising if `e[i+1]=1`.
- Qualifying edges are masked by `edge_sel`; disabled channels never assert `tag_valid`, `tag_rising` or `tag_multi`.
- Reported subtime is the lowest qualifying index (priority encoder, LSB first). `tag_multi`=1 iff popcount of qualifying edges ≥2.
- History priming: after reset, the first accepted word only loads `last_c`; no edge is detected in that cycle for any channel. A flag `primed` (reset 0) is set at the end of that cycle.
- `last_c` updates every cycle regardless of `edge_sel`, so enabling a channel mid-run never fabricates an edge.
- Coarse counter: `COUNTER_BITS` wide, resets to 0, increments by 1 every cycle after reset, wraps modulo `2^COUNTER_BITS`. The tag's coarse field is the counter value in the cycle the word was sampled, not the output cycle.
- Channels are fully independent; simultaneous tags on all channels are legal and all reported in the same cycle.

## Timing
- Two-stage pipeline. Stage 1 registers samples, `edge_sel`, per-channel previous last bit and coarse count. Stage 2 registers edge decode, priority encoding and outputs.
- A word presented at edge t produces outputs visible after edge t+2; throughput is one word per cycle per channel, with no stalls and no backpressure.
- Reset values: `tag_valid`=0, `tag_time`=0, `tag_rising`=0, `tag_multi`=0, `coarse_wrap`=0, counter=0, all `last_c`=0, `primed`=0, and pipeline valid bits cleared.
- Reset asserted mid-operation: in-flight words are discarded; outputs are 0 from the cycle after the reset edge; priming restarts.
- `coarse_wrap` is aligned with the output stage: it asserts in the same cycle as tags whose coarse field is 0 after a wrap.

## Test plan
- Priming: after reset, the first word for ch0 is 4'b1111, edge_sel=11 (BITS=2). Required: no tag. Next word 4'b1111 -> no tag.
- Rising inside word: previous last=0, ch0 word 4'b1100, sel=01, sampled at counter=5. Required: two cycles later `tag_valid[0]`=1, time={5,2'd2}, rising=1, multi=0.
- Boundary falling: previous last=1, word 4'b0000, sel=10. Required: subtime 0, rising=0. Same stimulus with sel=01 -> no tag.
- Multi-edge: previous last=0, word 4'b0101. Required with sel=11: subtime 0, rising=1, multi=1. With sel=01: subtime 0, multi=1. With sel=10: subtime 1, rising=0, multi=1.
- Parallel channels and wrap: COUNTER_BITS=4, all four channels get rising edges at distinct indices in the word sampled at counter=15 and again at 0. Required: four tags with coarse 15, then four with coarse 0, with `coarse_wrap`=1 in the latter output cycle only.
- Mid-run reset: assert `rst` for one cycle while edges are in flight. Required: outputs 0 from the next cycle, counter restarts at 0, and the first post-reset word yields no tag.

Source files
------------

// File: rtl/tagger_edge_encoder_if.sv
// -----------------------------------------------------------------------------
// tagger_edge_encoder_if
// Bus between the deserialising input samplers / tag FIFO and the edge encoder.
//   samples     : CHANNELS*N oversampled bits, channel c at [c*N +: N],
//                 bit 0 earliest in time
//   edge_sel    : 2 bits per channel, 00 off, 01 rising, 10 falling, 11 both
//   tag_valid   : per-channel tag present
//   tag_time    : per-channel {coarse, subtime}, COUNTER_BITS+BITS wide
//   tag_rising  : per-channel polarity of the reported edge
//   tag_multi   : per-channel more than one qualifying edge in the word
//   coarse_wrap : pulse aligned with tags whose coarse field wrapped to 0
// master = sampler/FIFO side, slave = encoder.
// -----------------------------------------------------------------------------
interface tagger_edge_encoder_if #(
   parameter int BITS         = 2,
   parameter int CHANNELS     = 4,
   parameter int COUNTER_BITS = 32
);
   localparam int N  = 1 << BITS;
   localparam int TW = COUNTER_BITS + BITS;

   logic [CHANNELS*N-1:0]  samples;
   logic [2*CHANNELS-1:0]  edge_sel;
   logic [CHANNELS-1:0]    tag_valid;
   logic [CHANNELS*TW-1:0] tag_time;
   logic [CHANNELS-1:0]    tag_rising;
   logic [CHANNELS-1:0]    tag_multi;
   logic                   coarse_wrap;

   modport master (
      output samples, edge_sel,
      input  tag_valid, tag_time, tag_rising, tag_multi, coarse_wrap
   );

   modport slave (
      input  samples, edge_sel,
      output tag_valid, tag_time, tag_rising, tag_multi, coarse_wrap
   );
endinterface

// File: rtl/tagger_edge_encoder.sv
// -----------------------------------------------------------------------------
// tagger_edge_encoder
// Multi-channel edge encoder. Each cycle every channel delivers N = 1<<BITS
// samples; the earliest qualifying edge (including one between the previous
// word's last sample and this word's first) is tagged with the coarse cycle
// count of the sampling cycle and its sub-cycle index.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : tagger_edge_encoder_if.slave (samples/edge_sel in, tags out)
// Pipeline: word captured on edge t+1 (stage 1), tags registered on edge t+2.
// -----------------------------------------------------------------------------
module tagger_edge_encoder #(
   parameter int BITS         = 2,
   parameter int CHANNELS     = 4,
   parameter int COUNTER_BITS = 32
) (
   input logic                  clk,
   input logic                  rst,
   tagger_edge_encoder_if.slave bus
);
   localparam int N  = 1 << BITS;
   localparam int TW = COUNTER_BITS + BITS;

   // Lowest set index; LSB is the earliest sample so it wins.
   function automatic logic [BITS-1:0] first_idx(input logic [N-1:0] q);
      logic [BITS-1:0] r;
      r = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (q[i]) r = i[BITS-1:0];
      end
      return r;
   endfunction

   // True when at least two bits are set (clearing the lowest leaves something).
   function automatic logic multi_hit(input logic [N-1:0] q);
      return (q & (q - N'(1))) != '0;
   endfunction

   logic [COUNTER_BITS-1:0] cnt;
   logic                    cnt_wrapped;
   logic                    primed;
   logic [CHANNELS-1:0]     last;

   logic [CHANNELS*N-1:0]   samples_p1;
   logic [2*CHANNELS-1:0]   sel_p1;
   logic [CHANNELS-1:0]     prev_p1;
   logic [COUNTER_BITS-1:0] coarse_p1;
   logic                    wrap_p1;
   logic                    primed_p1;
   logic                    vld_p1;

   logic [CHANNELS-1:0]     hit;
   logic [CHANNELS-1:0]     hit_rise;
   logic [CHANNELS-1:0]     hit_multi;
   logic [CHANNELS*TW-1:0]  hit_time;

   logic [CHANNELS-1:0]     tag_valid_p2;
   logic [CHANNELS*TW-1:0]  tag_time_p2;
   logic [CHANNELS-1:0]     tag_rising_p2;
   logic [CHANNELS-1:0]     tag_multi_p2;
   logic                    coarse_wrap_p2;

   // ---- stage 1: capture word, selection, history bit and coarse count ----
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt         <= '0;
         cnt_wrapped <= 1'b0;
         primed      <= 1'b0;
         last        <= '0;
         vld_p1      <= 1'b0;
         primed_p1   <= 1'b0;
         wrap_p1     <= 1'b0;
      end else begin
         cnt         <= cnt + 1'b1;
         // High during the cycle whose count is 0 right after all-ones.
         cnt_wrapped <= &cnt;
         primed      <= 1'b1;
         vld_p1      <= 1'b1;
         primed_p1   <= primed;
         wrap_p1     <= cnt_wrapped;
         // History follows the input even for disabled channels, so enabling
         // a channel later starts from the real line level.
         for (int c = 0; c < CHANNELS; c++) begin
            last[c] <= bus.samples[c*N + N - 1];
         end
      end
      samples_p1 <= bus.samples;
      sel_p1     <= bus.edge_sel;
      prev_p1    <= last;
      coarse_p1  <= cnt;
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic [N:0]      e;
      logic [N-1:0]    edges;
      logic [N-1:0]    rise;
      logic [N-1:0]    qual;
      logic [BITS-1:0] idx;

      assign e     = {samples_p1[c*N +: N], prev_p1[c]};
      assign rise  = e[N:1];
      assign edges = e[N:1] ^ e[N-1:0];
      assign qual  = edges & (({N{sel_p1[2*c]}} & rise) | ({N{sel_p1[2*c+1]}} & ~rise));
      assign idx   = first_idx(qual);

      // The first word after reset only seeds the history.
      assign hit[c]                 = vld_p1 & primed_p1 & (|qual);
      assign hit_rise[c]            = rise[idx];
      assign hit_multi[c]           = multi_hit(qual);
      assign hit_time[c*TW +: TW]   = {coarse_p1, idx};
   end

   // ---- stage 2: register decoded tags ----
   always_ff @(posedge clk) begin
      if (rst) begin
         tag_valid_p2   <= '0;
         tag_time_p2    <= '0;
         tag_rising_p2  <= '0;
         tag_multi_p2   <= '0;
         coarse_wrap_p2 <= 1'b0;
      end else begin
         tag_valid_p2   <= hit;
         tag_rising_p2  <= hit & hit_rise;
         tag_multi_p2   <= hit & hit_multi;
         coarse_wrap_p2 <= vld_p1 & wrap_p1;
         for (int c = 0; c < CHANNELS; c++) begin
            tag_time_p2[c*TW +: TW] <= hit[c] ? hit_time[c*TW +: TW] : '0;
         end
      end
   end

   assign bus.tag_valid   = tag_valid_p2;
   assign bus.tag_time    = tag_time_p2;
   assign bus.tag_rising  = tag_rising_p2;
   assign bus.tag_multi   = tag_multi_p2;
   assign bus.coarse_wrap = coarse_wrap_p2;
endmodule
